mfp_ahb_intc: RTL and testbench

Parametrised AHB-Lite interrupt controller that aggregates up to 31 peripheral interrupt sources, such as robot-update strobes and UART events, into one processor interrupt line. It has per-source enable, edge/level mode, polarity, software force and a claim/acknowledge handshake. It sits on the system AHB-Lite bus as a slave alongside the GPIO/UART decoders. Its `irq` output drives one `SI_Int` pin of the core, which replaces the hard-tied zero interrupt bus.

---
 rtl/mfp_ahb_intc_if.sv | 24 ++
 rtl/mfp_ahb_intc.sv | 123 ++++++++++++
 tb/tb_mfp_ahb_intc.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_ahb_intc_if.sv
// AHB-Lite slave-side bus bundle for the interrupt controller.
// The fabric (or a bench) drives the master side; the controller uses the slave side.
interface mfp_ahb_intc_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/mfp_ahb_intc.sv
// AHB-Lite interrupt controller: per-source sync, edge/level/polarity/force,
// fixed lowest-index priority and a claim read that clears and acknowledges.
module mfp_ahb_intc #(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             HCLK,
    input  logic             SI_Reset,
    mfp_ahb_intc_if.slave    bus,
    input  logic [N_SRC-1:0] src_in,
    output logic [N_SRC-1:0] src_ack,
    output logic             irq,
    output logic [4:0]       irq_idx
);
    localparam logic [2:0] A_PENDING = 3'd0;
    localparam logic [2:0] A_ENABLE  = 3'd1;
    localparam logic [2:0] A_MODE    = 3'd2;
    localparam logic [2:0] A_POL     = 3'd3;
    localparam logic [2:0] A_CLAIM   = 3'd4;
    localparam logic [2:0] A_FORCE   = 3'd5;

    logic [N_SRC-1:0] sync_reg [SYNC_STAGES];
    logic [N_SRC-1:0] act, act_prev_reg;
    logic [N_SRC-1:0] pending_reg, pending_next;
    logic [N_SRC-1:0] force_hold_reg, force_hold_next;
    logic [N_SRC-1:0] enable_reg, mode_reg, polarity_reg;
    logic [N_SRC-1:0] active, low_onehot, wdata;
    logic [N_SRC-1:0] force_set, w1c_clr, claim_clr, clr;
    logic             dp_valid_reg, dp_write_reg;
    logic [2:0]       dp_addr_reg;
    logic             wr_commit, rd_active, any_active, claim_valid;
    logic [4:0]       low_idx;
    logic             unused_bits;

    assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0], bus.HWDATA[31:N_SRC]};

    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

    assign active     = pending_reg & enable_reg;
    assign any_active = |active;
    assign low_onehot = active & (-active);

    always_comb begin
        low_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) low_idx = 5'(i);
        end
    end

    assign wdata       = bus.HWDATA[N_SRC-1:0];
    assign wr_commit   = dp_valid_reg & dp_write_reg & bus.HREADY;
    assign rd_active   = dp_valid_reg & ~dp_write_reg;
    assign force_set   = (wr_commit && dp_addr_reg == A_FORCE)   ? wdata : '0;
    assign w1c_clr     = (wr_commit && dp_addr_reg == A_PENDING) ? wdata : '0;
    assign claim_valid = rd_active & bus.HREADY & (dp_addr_reg == A_CLAIM) & any_active;
    assign claim_clr   = claim_valid ? low_onehot : '0;
    assign clr         = w1c_clr | claim_clr;

    // Set terms are OR'd after the clear mask so a same-cycle set always wins.
    // Level-mode forced bits live in force_hold so they survive act dropping to 0.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
        assign act[gi]             = sync_reg[SYNC_STAGES-1][gi] ^ polarity_reg[gi];
        assign force_hold_next[gi] = force_set[gi] | (force_hold_reg[gi] & ~clr[gi]);
        assign pending_next[gi]    = mode_reg[gi]
            ? ((act[gi] & ~act_prev_reg[gi]) | force_set[gi] | (pending_reg[gi] & ~clr[gi]))
            : (act[gi] | force_hold_next[gi]);
    end

    always_comb begin
        bus.HRDATA = '0;
        if (rd_active) begin
            case (dp_addr_reg)
                A_PENDING: bus.HRDATA = 32'(pending_reg);
                A_ENABLE:  bus.HRDATA = 32'(enable_reg);
                A_MODE:    bus.HRDATA = 32'(mode_reg);
                A_POL:     bus.HRDATA = 32'(polarity_reg);
                A_CLAIM:   bus.HRDATA = any_active ? {1'b1, 26'd0, low_idx} : 32'd0;
                default:   bus.HRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge SI_Reset) begin
        if (SI_Reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
            act_prev_reg   <= '0;
            pending_reg    <= '0;
            force_hold_reg <= '0;
            enable_reg     <= '0;
            mode_reg       <= '0;
            polarity_reg   <= '0;
            dp_valid_reg   <= 1'b0;
            dp_write_reg   <= 1'b0;
            dp_addr_reg    <= '0;
            irq            <= 1'b0;
            irq_idx        <= '0;
            src_ack        <= '0;
        end else begin
            sync_reg[0] <= src_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
            act_prev_reg   <= act;
            pending_reg    <= pending_next;
            force_hold_reg <= force_hold_next;
            if (bus.HREADY) begin
                dp_valid_reg <= bus.HSEL & bus.HTRANS[1];
                dp_write_reg <= bus.HWRITE;
                dp_addr_reg  <= bus.HADDR[4:2];
            end
            if (wr_commit) begin
                case (dp_addr_reg)
                    A_ENABLE: enable_reg   <= wdata;
                    A_MODE:   mode_reg     <= wdata;
                    A_POL:    polarity_reg <= wdata;
                    default:  ;
                endcase
            end
            irq     <= any_active;
            irq_idx <= low_idx;
            src_ack <= claim_clr;
        end
    end
endmodule

// File: tb/tb_mfp_ahb_intc.sv
// Directed bench for mfp_ahb_intc: register vector table plus hand-written
// sequences for latency, priority/claim, level/polarity, collision and pipelining.
module tb_mfp_ahb_intc;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src_in = '0;
    logic [7:0] src_ack;
    logic       irq;
    logic [4:0] irq_idx;
    logic [3:0] src_in4 = '0;
    logic [3:0] src_ack4;
    logic       irq4;
    logic [4:0] irq_idx4;

    int n_cmp  = 0;
    int n_fail = 0;

    mfp_ahb_intc_if bus();
    mfp_ahb_intc_if bus4();

    always #5 clk = ~clk;

    mfp_ahb_intc #(.N_SRC(8), .SYNC_STAGES(2)) dut (
        .HCLK(clk), .SI_Reset(rst), .bus(bus),
        .src_in(src_in), .src_ack(src_ack), .irq(irq), .irq_idx(irq_idx)
    );

    mfp_ahb_intc #(.N_SRC(4), .SYNC_STAGES(2)) dut4 (
        .HCLK(clk), .SI_Reset(rst), .bus(bus4),
        .src_in(src_in4), .src_ack(src_ack4), .irq(irq4), .irq_idx(irq_idx4)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    localparam logic [31:0] R_PEND  = 32'h00;
    localparam logic [31:0] R_EN    = 32'h04;
    localparam logic [31:0] R_MODE  = 32'h08;
    localparam logic [31:0] R_POL   = 32'h0C;
    localparam logic [31:0] R_CLAIM = 32'h10;
    localparam logic [31:0] R_FORCE = 32'h14;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end else begin
            $display("ok   %s: %08h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HADDR  = a;
    endtask

    task automatic idle_phase();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr_phase(1'b1, a);
        tick();
        bus.HWDATA = d;
        idle_phase();
        tick();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr_phase(1'b0, a);
        tick();
        idle_phase();
        d = bus.HRDATA;
        tick();
    endtask

    vec_t vecs [29];
    logic [31:0] rd;

    initial begin
        vecs[0]  = '{1'b0, R_PEND,  32'h0, 32'h0};
        vecs[1]  = '{1'b0, R_EN,    32'h0, 32'h0};
        vecs[2]  = '{1'b0, R_MODE,  32'h0, 32'h0};
        vecs[3]  = '{1'b0, R_POL,   32'h0, 32'h0};
        vecs[4]  = '{1'b0, R_CLAIM, 32'h0, 32'h0};
        vecs[5]  = '{1'b0, R_FORCE, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 32'h18,  32'h0, 32'h0};
        vecs[7]  = '{1'b0, 32'h1C,  32'h0, 32'h0};
        vecs[8]  = '{1'b1, R_EN,    32'hFFFF_FF5A, 32'h0};
        vecs[9]  = '{1'b0, R_EN,    32'h0, 32'h0000_005A};
        vecs[10] = '{1'b1, R_MODE,  32'hFFFF_FFFF, 32'h0};
        vecs[11] = '{1'b0, R_MODE,  32'h0, 32'h0000_00FF};
        vecs[12] = '{1'b1, 32'h1C,  32'h1234_5678, 32'h0};
        vecs[13] = '{1'b0, 32'h1C,  32'h0, 32'h0};
        vecs[14] = '{1'b1, 32'h18,  32'hFFFF_FFFF, 32'h0};
        vecs[15] = '{1'b0, 32'h18,  32'h0, 32'h0};
        vecs[16] = '{1'b0, R_PEND,  32'h0, 32'h0};
        vecs[17] = '{1'b0, R_CLAIM, 32'h0, 32'h0};
        vecs[18] = '{1'b1, R_POL,   32'h0000_0001, 32'h0};
        vecs[19] = '{1'b0, R_POL,   32'h0, 32'h0000_0001};
        vecs[20] = '{1'b0, R_PEND,  32'h0, 32'h0000_0001};
        vecs[21] = '{1'b0, R_CLAIM, 32'h0, 32'h0};
        vecs[22] = '{1'b1, R_EN,    32'h0000_0001, 32'h0};
        vecs[23] = '{1'b0, R_CLAIM, 32'h0, 32'h8000_0000};
        vecs[24] = '{1'b0, R_PEND,  32'h0, 32'h0};
        vecs[25] = '{1'b1, R_POL,   32'h0, 32'h0};
        vecs[26] = '{1'b1, R_EN,    32'h0, 32'h0};
        vecs[27] = '{1'b1, R_MODE,  32'h0, 32'h0};
        vecs[28] = '{1'b0, R_PEND,  32'h0, 32'h0};

        idle_phase();
        bus.HREADY = 1'b1;
        bus.HSIZE  = 3'd2;
        bus.HWDATA = '0;
        bus4.HSEL = 1'b0; bus4.HTRANS = 2'b00; bus4.HWRITE = 1'b0; bus4.HADDR = '0;
        bus4.HREADY = 1'b1; bus4.HSIZE = 3'd2; bus4.HWDATA = '0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_irq_idx", 32'(irq_idx), 32'h0);
        check("reset_src_ack", 32'(src_ack), 32'h0);
        check("reset_hrdata", bus.HRDATA, 32'h0);
        check("reset_hreadyout", 32'(bus.HREADYOUT), 32'h1);
        check("reset_hresp", 32'(bus.HRESP), 32'h0);
        tick();

        // Mid-operation asynchronous reset
        bus_write(R_POL, 32'h03);
        bus_write(R_EN, 32'h01);
        bus_write(R_FORCE, 32'h01);
        tick();
        check("pre_reset_irq", 32'(irq), 32'h1);
        #3 rst = 1'b1;
        #1;
        check("async_reset_irq", 32'(irq), 32'h0);
        check("async_reset_src_ack", 32'(src_ack), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Register vector table
        for (int i = 0; i < 29; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr[7:0]), rd, vecs[i].exp);
            end
        end

        // Edge capture latency and claim
        bus_write(R_MODE, 32'h01);
        bus_write(R_EN, 32'h01);
        src_in[0] = 1'b1;
        tick();
        tick();
        addr_phase(1'b0, R_PEND);
        tick();
        idle_phase();
        check("edge_pending_at_e3", bus.HRDATA, 32'h1);
        check("edge_irq_not_at_e3", 32'(irq), 32'h0);
        src_in[0] = 1'b0;
        tick();
        check("edge_irq_at_e4", 32'(irq), 32'h1);
        check("edge_irq_idx", 32'(irq_idx), 32'h0);
        bus_read(R_CLAIM, rd);
        check("edge_claim", rd, 32'h8000_0000);
        check("edge_ack_pulse", 32'(src_ack), 32'h01);
        tick();
        check("edge_ack_gone", 32'(src_ack), 32'h00);
        check("edge_irq_cleared", 32'(irq), 32'h0);
        bus_read(R_PEND, rd);
        check("edge_pending_cleared", rd, 32'h0);

        // Priority and successive claims
        bus_write(R_MODE, 32'hFF);
        bus_write(R_EN, 32'h28);
        src_in = 8'h28;
        repeat (3) tick();
        src_in = 8'h00;
        repeat (3) tick();
        check("prio_irq", 32'(irq), 32'h1);
        check("prio_irq_idx", 32'(irq_idx), 32'h3);
        bus_read(R_CLAIM, rd);
        check("prio_claim1", rd, 32'h8000_0003);
        check("prio_ack1", 32'(src_ack), 32'h08);
        bus_read(R_CLAIM, rd);
        check("prio_claim2", rd, 32'h8000_0005);
        check("prio_ack2", 32'(src_ack), 32'h20);
        bus_read(R_CLAIM, rd);
        check("prio_claim3", rd, 32'h0);
        check("prio_ack3_none", 32'(src_ack), 32'h00);
        tick();
        check("prio_irq_off", 32'(irq), 32'h0);

        // Level mode with active-low polarity
        bus_write(R_MODE, 32'h00);
        bus_write(R_POL, 32'h04);
        bus_write(R_EN, 32'h04);
        bus_read(R_PEND, rd);
        check("level_pending", rd, 32'h04);
        bus_write(R_PEND, 32'h04);
        bus_read(R_PEND, rd);
        check("level_w1c_no_effect", rd, 32'h04);
        bus_read(R_CLAIM, rd);
        check("level_claim", rd, 32'h8000_0002);
        check("level_ack", 32'(src_ack), 32'h04);
        bus_read(R_PEND, rd);
        check("level_claim_no_effect", rd, 32'h04);
        src_in[2] = 1'b1;
        repeat (3) tick();
        bus_read(R_PEND, rd);
        check("level_released", rd, 32'h00);
        src_in[2] = 1'b0;
        bus_write(R_POL, 32'h00);

        // Edge set colliding with W1C commit
        bus_write(R_MODE, 32'h02);
        bus_write(R_EN, 32'h02);
        src_in[1] = 1'b1;
        tick();
        bus_write(R_PEND, 32'h02);
        bus_read(R_PEND, rd);
        check("collision_set_wins", rd, 32'h02);
        src_in[1] = 1'b0;
        bus_write(R_PEND, 32'h02);
        bus_read(R_PEND, rd);
        check("edge_w1c_clears", rd, 32'h00);

        // Back-to-back FORCE write then PENDING read
        bus_write(R_MODE, 32'hFF);
        bus_write(R_EN, 32'h00);
        addr_phase(1'b1, R_FORCE);
        tick();
        bus.HWDATA = 32'h80;
        addr_phase(1'b0, R_PEND);
        tick();
        idle_phase();
        check("b2b_force_read", bus.HRDATA, 32'h80);
        tick();
        bus_write(R_PEND, 32'h80);
        bus_read(R_PEND, rd);
        check("force_w1c", rd, 32'h00);

        // N_SRC=4 instance: upper bits masked, read-after-write back to back
        bus4.HSEL = 1'b1; bus4.HTRANS = 2'b10; bus4.HWRITE = 1'b1; bus4.HADDR = R_EN;
        tick();
        bus4.HWDATA = 32'hFFFF_FFFF;
        bus4.HWRITE = 1'b0;
        tick();
        bus4.HSEL = 1'b0; bus4.HTRANS = 2'b00;
        check("n4_enable_masked", bus4.HRDATA, 32'h0000_000F);
        tick();
        check("n4_hrdata_idle", bus4.HRDATA, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
